tlb_repl_state: RTL

Owns the replacement state of the 8-entry TLB: per-entry valid bits and the 7-bit PLRU tree. Both vectors are driven into the combinational victim selector, and the selector's chosen entry comes back as victim_in. The block sequences a refill: it accepts a miss, latches the victim, waits for the page-table walker, then commits the write. It also updates the PLRU tree on lookup hits and clears the valid bits on flush.

---
 rtl/tlb_repl_state.sv | 109 ++++++++++
 1 files changed

// File: rtl/tlb_repl_state.sv
// tlb_repl_state: replacement state (valid bits + 3-level PLRU tree) and refill sequencer for an 8-entry TLB.
// Ports: clk/reset (sync, active-high); lookup_valid/lookup_hit/lookup_hit_idx touch the tree on hits;
// flush clears all valid bits; miss_req_valid/miss_req_ready hand over a miss and victim_in is latched;
// ptw_resp_valid/ptw_resp_error close the walk; refill_we/refill_idx strobe the entry write;
// plru/valid feed the victim selector; busy is high outside IDLE.
// Optional feature: define TLB_REFILL_TIMEOUT_EN to abandon a walk after TIMEOUT_CYCLES WAIT cycles.
module tlb_repl_state #(
  parameter int ENTRIES = 8
`ifdef TLB_REFILL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic               lookup_hit,
  input  logic [2:0]         lookup_hit_idx,
  input  logic               flush,
  input  logic               miss_req_valid,
  output logic               miss_req_ready,
  input  logic [2:0]         victim_in,
  input  logic               ptw_resp_valid,
  input  logic               ptw_resp_error,
  output logic [ENTRIES-1:0] plru,
  output logic [ENTRIES-1:0] valid,
  output logic               refill_we,
  output logic [2:0]         refill_idx,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_e;
  state_e             state_q;
  logic               ready_q;
  logic               kill_q;
  logic [2:0]         refill_idx_q;
  logic [ENTRIES-1:0] plru_q, plru_d, plru_h;
  logic [ENTRIES-1:0] valid_q, valid_d;
`ifdef TLB_REFILL_TIMEOUT_EN
  logic [7:0]         cnt_q;
`endif
  // Point every node on the path to e away from e; bit0 is never written.
  function automatic logic [ENTRIES-1:0] touch(input logic [ENTRIES-1:0] p, input logic [2:0] e);
    logic [ENTRIES-1:0] r;
    r = p;
    r[1] = ~e[2];
    r[{2'b01, e[2]}] = ~e[1];
    r[{1'b1, e[2:1]}] = ~e[0];
    return r;
  endfunction
  assign refill_we      = (state_q == COMMIT) && !flush;
  assign refill_idx     = refill_idx_q;
  assign miss_req_ready = ready_q;
  assign busy           = state_q != IDLE;
  assign plru           = plru_q;
  assign valid          = valid_q;
  // Hit touch first, refill touch second so the refill owns shared nodes.
  always_comb begin
    plru_h  = (lookup_valid && lookup_hit) ? touch(plru_q, lookup_hit_idx) : plru_q;
    plru_d  = refill_we ? touch(plru_h, refill_idx_q) : plru_h;
    valid_d = flush ? '0 : refill_we ? valid_q | (ENTRIES'(1) << refill_idx_q) : valid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      kill_q       <= 1'b0;
      refill_idx_q <= '0;
      plru_q       <= '0;
      valid_q      <= '0;
`ifdef TLB_REFILL_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      plru_q  <= plru_d;
      valid_q <= valid_d;
      case (state_q)
        IDLE: if (miss_req_valid) begin
          refill_idx_q <= victim_in;
          kill_q       <= 1'b0;
          state_q      <= WAIT;
          ready_q      <= 1'b0;
`ifdef TLB_REFILL_TIMEOUT_EN
          cnt_q        <= '0;
`endif
        end
        WAIT: begin
          // A flush during the walk poisons the entry it will return.
          kill_q <= kill_q | flush;
`ifdef TLB_REFILL_TIMEOUT_EN
          cnt_q  <= cnt_q + 8'd1;
`endif
          if (ptw_resp_valid) begin
            state_q <= (ptw_resp_error || kill_q || flush) ? IDLE : COMMIT;
            ready_q <= ptw_resp_error || kill_q || flush;
          end
`ifdef TLB_REFILL_TIMEOUT_EN
          else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule
